// File: rtl/wb_result_merger_if.sv
// Bundle of the per-producer writeback inputs and the merged scoreboard port.
// The merger takes the slave view; producers and scoreboard drive the master view.
interface wb_result_merger_if #(
  parameter int unsigned NrSrc       = 5,
  parameter int unsigned XLEN        = 64,
  parameter int unsigned TransIdBits = 3
);
  localparam int unsigned SrcW = (NrSrc > 1) ? $clog2(NrSrc) : 1;

  logic [NrSrc-1:0]                  src_valid_i;
  logic [NrSrc-1:0][TransIdBits-1:0] src_trans_id_i;
  logic [NrSrc-1:0][XLEN-1:0]        src_result_i;
  logic [NrSrc-1:0]                  src_ex_valid_i;
  logic [NrSrc-1:0][XLEN-1:0]        src_ex_cause_i;
  logic [NrSrc-1:0][XLEN-1:0]        src_ex_tval_i;
  logic [NrSrc-1:0]                  src_ready_o;

  logic                   wb_valid_o;
  logic                   wb_ready_i;
  logic [SrcW-1:0]        wb_src_o;
  logic [TransIdBits-1:0] wb_trans_id_o;
  logic [XLEN-1:0]        wb_result_o;
  logic                   wb_ex_valid_o;
  logic [XLEN-1:0]        wb_ex_cause_o;
  logic [XLEN-1:0]        wb_ex_tval_o;

  modport master (
    output src_valid_i, src_trans_id_i, src_result_i,
           src_ex_valid_i, src_ex_cause_i, src_ex_tval_i, wb_ready_i,
    input  src_ready_o, wb_valid_o, wb_src_o, wb_trans_id_o, wb_result_o,
           wb_ex_valid_o, wb_ex_cause_o, wb_ex_tval_o
  );

  modport slave (
    input  src_valid_i, src_trans_id_i, src_result_i,
           src_ex_valid_i, src_ex_cause_i, src_ex_tval_i, wb_ready_i,
    output src_ready_o, wb_valid_o, wb_src_o, wb_trans_id_o, wb_result_o,
           wb_ex_valid_o, wb_ex_cause_o, wb_ex_tval_o
  );
endinterface

// File: rtl/wb_result_merger.sv
// Merges execute-stage writeback results through per-source FIFOs and a round-robin
// arbiter onto one scoreboard port; one cycle minimum latency, pops only on wb_ready_i.
module wb_result_merger #(
  parameter int unsigned NrSrc       = 5,
  parameter int unsigned Depth       = 2,
  parameter int unsigned XLEN        = 64,
  parameter int unsigned TransIdBits = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  wb_result_merger_if.slave bus,
  output logic              overflow_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;
  localparam int unsigned SrcW = (NrSrc > 1) ? $clog2(NrSrc) : 1;
  localparam logic [CntW-1:0] DepthC  = CntW'(Depth);
  localparam logic [SrcW-1:0] LastSrc = SrcW'(NrSrc - 1);

  typedef struct packed {
    logic [TransIdBits-1:0] trans_id;
    logic [XLEN-1:0]        result;
    logic                   ex_valid;
    logic [XLEN-1:0]        ex_cause;
    logic [XLEN-1:0]        ex_tval;
  } entry_t;

  entry_t          mem_q  [NrSrc][Depth];
  entry_t          din    [NrSrc];
  logic [PtrW-1:0] wptr_q [NrSrc];
  logic [PtrW-1:0] wptr_d [NrSrc];
  logic [PtrW-1:0] rptr_q [NrSrc];
  logic [PtrW-1:0] rptr_d [NrSrc];
  logic [CntW-1:0] cnt_q  [NrSrc];
  logic [CntW-1:0] cnt_d  [NrSrc];
  logic [SrcW-1:0] rr_q, rr_d;
  logic            overflow_q, overflow_d;

  logic [NrSrc-1:0] cand, full, push, pop, drop;
  logic [SrcW-1:0]  grant, idx;
  logic             found, wb_vld, pop_vld;
  entry_t           head;

  always_comb begin
    for (int i = 0; i < NrSrc; i++) begin
      din[i].trans_id = bus.src_trans_id_i[i];
      din[i].result   = bus.src_result_i[i];
      din[i].ex_valid = bus.src_ex_valid_i[i];
      din[i].ex_cause = bus.src_ex_cause_i[i];
      din[i].ex_tval  = bus.src_ex_tval_i[i];
    end
  end

  always_comb begin
    cand = '0;
    full = '0;
    for (int i = 0; i < NrSrc; i++) begin
      cand[i] = (cnt_q[i] != '0);
      full[i] = (cnt_q[i] == DepthC);
    end
  end

  // Round-robin scan starting at rr_q; the first non-empty FIFO wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < NrSrc; k++) begin
      idx = SrcW'((int'(rr_q) + k) % NrSrc);
      if (!found && cand[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  assign wb_vld  = |cand;
  assign pop_vld = wb_vld && bus.wb_ready_i;

  // A full FIFO still accepts a push when its head leaves in the same cycle.
  always_comb begin
    pop  = '0;
    push = '0;
    drop = '0;
    for (int i = 0; i < NrSrc; i++) begin
      pop[i]    = pop_vld && (grant == SrcW'(i));
      push[i]   = bus.src_valid_i[i] && !flush_i && (!full[i] || pop[i]);
      drop[i]   = bus.src_valid_i[i] && !flush_i && full[i] && !pop[i];
      wptr_d[i] = wptr_q[i];
      rptr_d[i] = rptr_q[i];
      cnt_d[i]  = cnt_q[i];
      if (flush_i) begin
        wptr_d[i] = '0;
        rptr_d[i] = '0;
        cnt_d[i]  = '0;
      end else begin
        if (push[i]) wptr_d[i] = wptr_q[i] + PtrW'(1);
        if (pop[i])  rptr_d[i] = rptr_q[i] + PtrW'(1);
        if (push[i] && !pop[i])      cnt_d[i] = cnt_q[i] + CntW'(1);
        else if (pop[i] && !push[i]) cnt_d[i] = cnt_q[i] - CntW'(1);
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (flush_i)      rr_d = '0;
    else if (pop_vld) rr_d = (grant == LastSrc) ? '0 : grant + SrcW'(1);
    overflow_d = overflow_q | (|drop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrSrc; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rr_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < NrSrc; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      rr_q       <= rr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the output mux silences everything while no FIFO holds data.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NrSrc; i++) begin
      if (rst_ni && push[i]) mem_q[i][wptr_q[i]] <= din[i];
    end
  end

  always_comb begin
    head = '0;
    if (wb_vld) head = mem_q[grant][rptr_q[grant]];
  end

  assign bus.src_ready_o   = ~full;
  assign bus.wb_valid_o    = wb_vld;
  assign bus.wb_src_o      = wb_vld ? grant : '0;
  assign bus.wb_trans_id_o = head.trans_id;
  assign bus.wb_result_o   = head.result;
  assign bus.wb_ex_valid_o = head.ex_valid;
  assign bus.wb_ex_cause_o = head.ex_cause;
  assign bus.wb_ex_tval_o  = head.ex_tval;
  assign overflow_o        = overflow_q;
endmodule

// File: tb/tb_wb_result_merger.sv
// Randomized and directed bench for wb_result_merger against a queue-based reference.
module tb_wb_result_merger;
  localparam int NSRC  = 5;
  localparam int DEPTH = 2;
  localparam int XL    = 64;
  localparam int TIDB  = 3;

  typedef struct packed {
    logic [TIDB-1:0] id;
    logic [XL-1:0]   res;
    logic            exv;
    logic [XL-1:0]   cause;
    logic [XL-1:0]   tval;
  } ent_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic flush_i = 1'b0;
  logic overflow_o;

  int checks = 0;
  int errors = 0;

  wb_result_merger_if #(.NrSrc(NSRC), .XLEN(XL), .TransIdBits(TIDB)) bus ();

  wb_result_merger #(.NrSrc(NSRC), .Depth(DEPTH), .XLEN(XL), .TransIdBits(TIDB)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .flush_i   (flush_i),
    .bus       (bus),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: one queue per source, a rotating start index and a sticky drop flag.
  ent_t mq [NSRC][$];
  int   rr = 0;
  bit   ovf = 1'b0;
  bit   model_on = 1'b0;

  always @(negedge clk) begin
    int   g;
    bit   ev;
    ent_t e;
    ev = 1'b0;
    g  = 0;
    for (int k = 0; k < NSRC; k++) begin
      if (!ev && mq[(rr + k) % NSRC].size() > 0) begin
        ev = 1'b1;
        g  = (rr + k) % NSRC;
      end
    end
    e = ev ? mq[g][0] : '0;
    if (model_on) begin
      chk("wb_valid", 64'(bus.wb_valid_o), 64'(ev));
      chk("wb_src", 64'(bus.wb_src_o), ev ? 64'(g) : 64'd0);
      chk("wb_trans_id", 64'(bus.wb_trans_id_o), 64'(e.id));
      chk("wb_result", bus.wb_result_o, e.res);
      chk("wb_ex_valid", 64'(bus.wb_ex_valid_o), 64'(e.exv));
      chk("wb_ex_cause", bus.wb_ex_cause_o, e.cause);
      chk("wb_ex_tval", bus.wb_ex_tval_o, e.tval);
      for (int s = 0; s < NSRC; s++)
        chk($sformatf("src_ready%0d", s), 64'(bus.src_ready_o[s]), 64'(mq[s].size() < DEPTH));
      chk("overflow", 64'(overflow_o), 64'(ovf));
    end
    if (!rst_ni) begin
      for (int s = 0; s < NSRC; s++) mq[s].delete();
      rr = 0;
      ovf = 1'b0;
      model_on = 1'b1;
    end else if (flush_i) begin
      for (int s = 0; s < NSRC; s++) mq[s].delete();
      rr = 0;
    end else begin
      if (ev && bus.wb_ready_i) begin
        void'(mq[g].pop_front());
        rr = (g + 1) % NSRC;
      end
      for (int s = 0; s < NSRC; s++) begin
        if (bus.src_valid_i[s]) begin
          if (mq[s].size() < DEPTH)
            mq[s].push_back({bus.src_trans_id_i[s], bus.src_result_i[s], bus.src_ex_valid_i[s],
                             bus.src_ex_cause_i[s], bus.src_ex_tval_i[s]});
          else
            ovf = 1'b1;
        end
      end
    end
  end

  task automatic push(input int s, input int id, input logic [63:0] res);
    bus.src_valid_i[s]    = 1'b1;
    bus.src_trans_id_i[s] = 3'(id);
    bus.src_result_i[s]   = res;
    bus.src_ex_valid_i[s] = res[0];
    bus.src_ex_cause_i[s] = res ^ 64'h55;
    bus.src_ex_tval_i[s]  = ~res;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.src_valid_i = '0;
    flush_i = 1'b0;
    rst_ni = 1'b1;
  endtask

  initial begin
    bus.src_valid_i    = '0;
    bus.src_trans_id_i = '0;
    bus.src_result_i   = '0;
    bus.src_ex_valid_i = '0;
    bus.src_ex_cause_i = '0;
    bus.src_ex_tval_i  = '0;
    bus.wb_ready_i     = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    chk("rst_valid", 64'(bus.wb_valid_o), 64'd0);
    chk("rst_ready", 64'(bus.src_ready_o), 64'h1f);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("rst_result", bus.wb_result_o, 64'd0);

    // single push from load
    push(1, 3, 64'hDEAD);
    tick();
    chk("t1_valid", 64'(bus.wb_valid_o), 64'd1);
    chk("t1_src", 64'(bus.wb_src_o), 64'd1);
    chk("t1_id", 64'(bus.wb_trans_id_o), 64'd3);
    chk("t1_res", bus.wb_result_o, 64'hDEAD);
    tick();
    chk("t1_drained", 64'(bus.wb_valid_o), 64'd0);
    flush_i = 1'b1;
    tick();

    // fairness
    for (int i = 0; i < NSRC; i++) push(i, i, 64'(100 + i));
    tick();
    for (int i = 0; i < NSRC; i++) begin
      chk("t2_src", 64'(bus.wb_src_o), 64'(i));
      chk("t2_id", 64'(bus.wb_trans_id_o), 64'(i));
      tick();
    end
    chk("t2_drained", 64'(bus.wb_valid_o), 64'd0);
    push(3, 1, 64'h33);
    push(0, 2, 64'h44);
    tick();
    chk("t2_rr0", 64'(bus.wb_src_o), 64'd0);
    tick();
    chk("t2_next", 64'(bus.wb_src_o), 64'd3);
    tick();

    // push and pop on a full FIFO
    bus.wb_ready_i = 1'b0;
    push(2, 5, 64'h5);
    tick();
    push(2, 6, 64'h6);
    tick();
    chk("t4_full", 64'(bus.src_ready_o[2]), 64'd0);
    chk("t4_head", 64'(bus.wb_trans_id_o), 64'd5);
    bus.wb_ready_i = 1'b1;
    push(2, 7, 64'h7);
    tick();
    chk("t4_id6", 64'(bus.wb_trans_id_o), 64'd6);
    chk("t4_still_full", 64'(bus.src_ready_o[2]), 64'd0);
    chk("t4_no_ovf", 64'(overflow_o), 64'd0);
    tick();
    chk("t4_id7", 64'(bus.wb_trans_id_o), 64'd7);
    tick();
    chk("t4_drained", 64'(bus.wb_valid_o), 64'd0);

    // backpressure and drop
    bus.wb_ready_i = 1'b0;
    push(0, 1, 64'h11);
    tick();
    push(0, 2, 64'h12);
    tick();
    chk("t3_full", 64'(bus.src_ready_o[0]), 64'd0);
    chk("t3_hold", 64'(bus.wb_trans_id_o), 64'd1);
    push(0, 4, 64'h14);
    tick();
    chk("t3_ovf", 64'(overflow_o), 64'd1);
    chk("t3_hold2", 64'(bus.wb_trans_id_o), 64'd1);
    bus.wb_ready_i = 1'b1;
    chk("t3_first", 64'(bus.wb_trans_id_o), 64'd1);
    tick();
    chk("t3_second", 64'(bus.wb_trans_id_o), 64'd2);
    tick();
    chk("t3_drained", 64'(bus.wb_valid_o), 64'd0);

    // flush with queued entries and a concurrent push
    bus.wb_ready_i = 1'b0;
    push(0, 1, 64'h21);
    push(3, 2, 64'h22);
    push(4, 3, 64'h23);
    tick();
    chk("t5_grant", 64'(bus.wb_src_o), 64'd3);
    flush_i = 1'b1;
    push(1, 4, 64'h24);
    tick();
    chk("t5_valid", 64'(bus.wb_valid_o), 64'd0);
    chk("t5_ready", 64'(bus.src_ready_o), 64'h1f);
    chk("t5_ovf", 64'(overflow_o), 64'd1);
    push(0, 5, 64'h25);
    push(1, 6, 64'h26);
    tick();
    chk("t5_rr0", 64'(bus.wb_src_o), 64'd0);
    bus.wb_ready_i = 1'b1;
    tick();
    chk("t5_next", 64'(bus.wb_src_o), 64'd1);
    tick();

    // reset mid-operation
    bus.wb_ready_i = 1'b0;
    push(2, 1, 64'h31);
    push(4, 2, 64'h32);
    tick();
    chk("t6_pre_valid", 64'(bus.wb_valid_o), 64'd1);
    rst_ni = 1'b0;
    tick();
    chk("t6_valid", 64'(bus.wb_valid_o), 64'd0);
    chk("t6_ovf", 64'(overflow_o), 64'd0);
    chk("t6_ready", 64'(bus.src_ready_o), 64'h1f);
    chk("t6_id", 64'(bus.wb_trans_id_o), 64'd0);
    chk("t6_src", 64'(bus.wb_src_o), 64'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < NSRC; s++) begin
        if ($urandom_range(0, 9) < 3) begin
          bus.src_valid_i[s]    = 1'b1;
          bus.src_trans_id_i[s] = 3'($urandom);
          bus.src_result_i[s]   = {$urandom, $urandom};
          bus.src_ex_valid_i[s] = 1'($urandom);
          bus.src_ex_cause_i[s] = {$urandom, $urandom};
          bus.src_ex_tval_i[s]  = {$urandom, $urandom};
        end
      end
      bus.wb_ready_i = ($urandom_range(0, 9) < 7);
      flush_i = ($urandom_range(0, 99) == 0);
      rst_ni = ($urandom_range(0, 499) != 0);
      tick();
    end
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
